// File: rtl/core_uart_apb.sv
// core_uart_apb: APB-mapped UART with 16x baud tick, single holding register per direction.
// Define CORE_UART_APB_FRAC_BAUD_EN to enable the fractional baud divisor (CTRL3).
module core_uart_apb #(
  parameter int          FAMILY         = 0,
  parameter int          TX_FIFO        = 0,
  parameter int          RX_FIFO        = 0,
  parameter int          FIXEDMODE      = 0,
  parameter logic [12:0] BAUD_VALUE     = 13'd1,
  parameter int          PRG_BIT8       = 1,
  parameter int          PRG_PARITY     = 0,
  parameter int          RX_LEGACY_MODE = 0,
  parameter logic [2:0]  BAUD_VAL_FRCTN = 3'd0
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [4:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  input  logic       RX,
  output logic       TX,
  output logic       TXRDY,
  output logic       RXRDY,
  output logic       PARITY_ERR,
  output logic       FRAMING_ERR,
  output logic       OVERFLOW
);
  localparam int   unused_cfg = FAMILY + TX_FIFO + RX_FIFO + int'(BAUD_VAL_FRCTN);
  localparam logic P_BIT8 = PRG_BIT8 != 0;
  localparam logic P_PEN  = PRG_PARITY != 0;
  localparam logic P_ODD  = PRG_PARITY == 2;
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_HOLD} rx_t;
  logic [12:0] baud_r, baud;
  logic        bit8_r, pen_r, odd_r, bit8, pen, odd;
  logic [2:0]  frac;
  logic        extra, tick;
  logic [13:0] bcnt;
  logic        wr, rd;
  tx_t         ts, ts_n;
  logic [3:0]  ttk;
  logic [2:0]  tbit;
  logic [7:0]  hold, tsh;
  logic        tend, tpar;
  rx_t         rs, rs_n;
  logic        rx1, rx2, rend, rpe, rfe, ferr, done;
  logic [3:0]  rtk;
  logic [2:0]  rbit;
  logic [7:0]  rsh, rxdata;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign wr = PSEL && PENABLE && PWRITE;
  assign rd = PSEL && PENABLE && !PWRITE;
  assign baud = FIXEDMODE != 0 ? BAUD_VALUE : baud_r;
  assign bit8 = FIXEDMODE != 0 ? P_BIT8 : bit8_r;
  assign pen  = FIXEDMODE != 0 ? P_PEN : pen_r;
  assign odd  = FIXEDMODE != 0 ? P_ODD : odd_r;
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      baud_r <= BAUD_VALUE;
      {odd_r, pen_r, bit8_r} <= {P_ODD, P_PEN, P_BIT8};
    end else if (wr && FIXEDMODE == 0) begin
      if (PADDR == 5'h08) baud_r[7:0] <= PWDATA;
      if (PADDR == 5'h0C) {baud_r[12:8], odd_r, pen_r, bit8_r} <= PWDATA;
    end
`ifdef CORE_UART_APB_FRAC_BAUD_EN
  logic [2:0] frac_r, tidx;
  assign frac  = FIXEDMODE != 0 ? BAUD_VAL_FRCTN : frac_r;
  assign extra = tidx < frac;
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      frac_r <= BAUD_VAL_FRCTN;
      tidx   <= 3'd0;
    end else begin
      if (wr && FIXEDMODE == 0 && PADDR == 5'h14) frac_r <= PWDATA[2:0];
      if (tick) tidx <= tidx + 3'd1;
    end
`else
  assign frac  = 3'd0;
  assign extra = 1'b0;
`endif
  // Reload value stretches the first frac ticks of each group of 8 by one cycle
  assign tick = bcnt == 14'd0;
  always_ff @(posedge PCLK)
    if (!PRESETN) bcnt <= {1'b0, BAUD_VALUE};
    else bcnt <= tick ? {1'b0, baud} + {13'd0, extra} : bcnt - 14'd1;
  assign tend = tick && ttk == 4'd15;
  assign tpar = ^(tsh & {bit8, 7'h7F}) ^ odd;
  assign TX = ts == T_START ? 1'b0 : ts == T_DATA ? tsh[tbit] : ts == T_PAR ? tpar : 1'b1;
  always_comb begin
    ts_n = ts;
    case (ts)
      T_IDLE:  if (!TXRDY) ts_n = T_START;
      T_START: if (tend) ts_n = T_DATA;
      T_DATA:  if (tend && tbit == (bit8 ? 3'd7 : 3'd6)) ts_n = pen ? T_PAR : T_STOP;
      T_PAR:   if (tend) ts_n = T_STOP;
      T_STOP:  if (tend) ts_n = T_IDLE;
      default: ts_n = T_IDLE;
    endcase
  end
  // TXRDY low doubles as "holding register full"
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      ts    <= T_IDLE;
      ttk   <= 4'd0;
      tbit  <= 3'd0;
      hold  <= 8'h00;
      tsh   <= 8'h00;
      TXRDY <= 1'b1;
    end else begin
      ts   <= ts_n;
      ttk  <= ts == T_IDLE ? 4'd0 : tick ? ttk + 4'd1 : ttk;
      tbit <= ts != T_DATA ? 3'd0 : tend ? tbit + 3'd1 : tbit;
      if (wr && PADDR == 5'h00 && TXRDY) begin
        hold  <= PWDATA;
        TXRDY <= 1'b0;
      end
      if (ts == T_IDLE && !TXRDY) begin
        tsh   <= hold;
        TXRDY <= 1'b1;
      end
    end
  assign rend = tick && rtk == 4'd15;
  assign ferr = rs == R_STOP ? !rx2 : rfe;
  assign done = rend && (RX_LEGACY_MODE != 0 ? rs == R_HOLD : rs == R_STOP);
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  if (!rx2) rs_n = R_START;
      R_START: if (tick && rtk == 4'd7) rs_n = rx2 ? R_IDLE : R_DATA;
      R_DATA:  if (rend && rbit == (bit8 ? 3'd7 : 3'd6)) rs_n = pen ? R_PAR : R_STOP;
      R_PAR:   if (rend) rs_n = R_STOP;
      R_STOP:  if (rend) rs_n = RX_LEGACY_MODE != 0 ? R_HOLD : R_IDLE;
      R_HOLD:  if (rend) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      {rx1, rx2} <= 2'b11;
      rs   <= R_IDLE;
      rtk  <= 4'd0;
      rbit <= 3'd0;
      rsh  <= 8'h00;
      rpe  <= 1'b0;
      rfe  <= 1'b0;
    end else begin
      rx1  <= RX;
      rx2  <= rx1;
      rs   <= rs_n;
      rtk  <= rs_n != rs ? 4'd0 : tick ? rtk + 4'd1 : rtk;
      rbit <= rs != R_DATA ? 3'd0 : rend ? rbit + 3'd1 : rbit;
      if (rs == R_IDLE) begin
        rsh <= 8'h00;
        rpe <= 1'b0;
      end
      if (rs == R_DATA && rend) rsh[rbit] <= rx2;
      if (rs == R_PAR && rend) rpe <= rx2 != (^rsh ^ odd);
      if (rs == R_STOP && rend) rfe <= !rx2;
    end
  // A completion in the same cycle as an RXDATA read overrides the clear
  always_ff @(posedge PCLK)
    if (!PRESETN) begin
      {RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW} <= 4'b0000;
      rxdata <= 8'h00;
    end else begin
      if (rd && PADDR == 5'h04) {RXRDY, PARITY_ERR, FRAMING_ERR, OVERFLOW} <= 4'b0000;
      if (done && RXRDY) OVERFLOW <= 1'b1;
      if (done && !RXRDY) begin
        rxdata      <= rsh;
        RXRDY       <= 1'b1;
        PARITY_ERR  <= rpe;
        FRAMING_ERR <= ferr;
      end
    end
  assign PRDATA = !(PSEL && !PWRITE) ? 8'h00 :
                  PADDR == 5'h04 ? rxdata :
                  PADDR == 5'h08 ? baud[7:0] :
                  PADDR == 5'h0C ? {baud[12:8], odd, pen, bit8} :
                  PADDR == 5'h10 ? {3'b000, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY} :
                  PADDR == 5'h14 ? {5'b00000, frac} : 8'h00;
endmodule

// File: tb/tb_core_uart_apb.sv
// tb_core_uart_apb: DUT1 TX loops into DUT2 RX; DUT3 is a fixed-format instance.
module tb_core_uart_apb;
  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [2:0] psel = 3'b000;
  logic       penable = 1'b0, pwrite = 1'b0;
  logic [4:0] paddr = 5'h00;
  logic [7:0] pwdata = 8'h00;
  logic [7:0] prd [3];
  logic [2:0] prdy, pslv, tx, txrdy, rxrdy, pe, fe, ov;
  logic       ovr_en = 1'b0, ovr_val = 1'b1, rx2_in;
  int         n_chk = 0, n_fail = 0, cyc = 0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  assign rx2_in = ovr_en ? ovr_val : tx[0];
  core_uart_apb u1 (.PCLK(pclk), .PRESETN(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prd[0]), .PREADY(prdy[0]), .PSLVERR(pslv[0]), .RX(1'b1),
    .TX(tx[0]), .TXRDY(txrdy[0]), .RXRDY(rxrdy[0]), .PARITY_ERR(pe[0]), .FRAMING_ERR(fe[0]), .OVERFLOW(ov[0]));
  core_uart_apb u2 (.PCLK(pclk), .PRESETN(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prd[1]), .PREADY(prdy[1]), .PSLVERR(pslv[1]), .RX(rx2_in),
    .TX(tx[1]), .TXRDY(txrdy[1]), .RXRDY(rxrdy[1]), .PARITY_ERR(pe[1]), .FRAMING_ERR(fe[1]), .OVERFLOW(ov[1]));
  core_uart_apb #(.FIXEDMODE(1), .BAUD_VALUE(13'h1A5), .PRG_PARITY(2)) u3 (.PCLK(pclk), .PRESETN(presetn),
    .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prd[2]),
    .PREADY(prdy[2]), .PSLVERR(pslv[2]), .RX(1'b1), .TX(tx[2]), .TXRDY(txrdy[2]), .RXRDY(rxrdy[2]),
    .PARITY_ERR(pe[2]), .FRAMING_ERR(fe[2]), .OVERFLOW(ov[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic apb_wr(input int d, input logic [4:0] a, input logic [7:0] v);
    @(posedge pclk); #1;
    psel = 3'b000; psel[d] = 1'b1; pwrite = 1'b1; paddr = a; pwdata = v; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1 psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input int d, input logic [4:0] a, output logic [7:0] v);
    @(posedge pclk); #1;
    psel = 3'b000; psel[d] = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk) v = prd[d];
    @(posedge pclk); #1 psel = 3'b000; penable = 1'b0;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    ovr_en = 1'b0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
  endtask

  // Writes a byte into DUT1 and checks every bit of the serial frame at mid-bit
  task automatic tx_frame(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                          input int bd, output int t0);
    int p = 16 * (bd + 1);
    int n = b8 ? 8 : 7;
    int nb = 1 + n + (pen ? 1 : 0);
    int t = 0;
    logic [7:0] m = b8 ? 8'hFF : 8'h7F;
    logic [11:0] fr = 12'hFFF;
    fr[0] = 1'b0;
    for (int i = 0; i < n; i++) fr[i+1] = d[i];
    if (pen) fr[n+1] = (($countones(d & m) % 2) == 1) ^ odd;
    apb_wr(0, 5'h00, d);
    check("txrdy_after_write", txrdy[0], 1'b0);
    while (tx[0] !== 1'b0 && t < 200) begin
      @(posedge pclk); #1;
      t++;
    end
    check("tx_start_seen", t < 200, 1'b1);
    t0 = cyc;
    for (int i = 0; i <= nb; i++) begin
      repeat (i == 0 ? p / 2 : p) @(posedge pclk);
      #1 check($sformatf("tx_bit%0d_of_%02h", i, d), tx[0], fr[i]);
    end
    check("txrdy_after_load", txrdy[0], 1'b1);
  endtask

  task automatic rx_expect(input logic [7:0] exp_d, input logic [7:0] exp_st, input int p,
                           input int nb, input int t0);
    int k = 0;
    int el;
    logic [7:0] v;
    while (!rxrdy[1] && k < 2 * p) begin
      @(posedge pclk); #1;
      k++;
    end
    check("rxrdy_set", rxrdy[1], 1'b1);
    el = cyc - t0;
    check($sformatf("rx_latency_%0d", el), el >= nb * p && el <= (nb + 1) * p, 1'b1);
    apb_rd(1, 5'h10, v);
    check("rx_status", v, exp_st);
    apb_rd(1, 5'h04, v);
    check("rx_data", v, exp_d);
    check("rxrdy_clr", rxrdy[1], 1'b0);
    apb_rd(1, 5'h10, v);
    check("status_after_read", v, 8'h01);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] v, d;
    int t0, bd, k;
    bit b8, pen, odd;
    do_reset();
    check("reset_tx", tx[0], 1'b1);
    check("reset_txrdy", txrdy[0], 1'b1);
    apb_rd(1, 5'h10, v); check("reset_status", v, 8'h01);
    apb_rd(0, 5'h08, v); check("reset_ctrl1", v, 8'h01);
    apb_rd(0, 5'h0C, v); check("reset_ctrl2", v, 8'h01);
    apb_rd(0, 5'h14, v); check("ctrl3_reads_zero", v, 8'h00);
    apb_rd(0, 5'h18, v); check("unmapped", v, 8'h00);
    tx_frame(8'h55, 1, 0, 0, 1, t0);
    rx_expect(8'h55, 8'h03, 32, 9, t0);
    for (int i = 0; i < 10; i++) begin
      bd = $urandom_range(1, 2);
      b8 = 1'($urandom_range(0, 1));
      pen = 1'($urandom_range(0, 1));
      odd = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      for (int u = 0; u < 2; u++) begin
        apb_wr(u, 5'h0C, {5'b0, odd, pen, b8});
        apb_wr(u, 5'h08, 8'(bd));
      end
      apb_rd(0, 5'h0C, v); check("ctrl2_readback", v, {5'b0, odd, pen, b8});
      tx_frame(d, b8, pen, odd, bd, t0);
      rx_expect(b8 ? d : {1'b0, d[6:0]}, 8'h03, 16 * (bd + 1), (b8 ? 9 : 8) + (pen ? 1 : 0), t0);
      repeat (16 * (bd + 1)) @(posedge pclk);
    end
    do_reset();
    apb_wr(0, 5'h0C, 8'h03);
    apb_wr(1, 5'h0C, 8'h07);
    tx_frame(8'hA5, 1, 1, 0, 1, t0);
    k = 0;
    while (!rxrdy[1] && k < 64) begin
      @(posedge pclk); #1;
      k++;
    end
    check("parity_err_port", pe[1], 1'b1);
    check("framing_err_port_p", fe[1], 1'b0);
    rx_expect(8'hA5, 8'h07, 32, 10, t0);
    do_reset();
    tx_frame(8'h3C, 1, 0, 0, 1, t0);
    tx_frame(8'hC3, 1, 0, 0, 1, t0);
    repeat (40) @(posedge pclk);
    #1 check("overflow_port", ov[1], 1'b1);
    apb_rd(1, 5'h10, v); check("overflow_status", v, 8'h0B);
    apb_rd(1, 5'h04, v); check("overflow_keeps_old", v, 8'h3C);
    check("overflow_cleared", ov[1], 1'b0);
    do_reset();
    ovr_en = 1'b1; ovr_val = 1'b0;
    k = 0;
    while (!rxrdy[1] && k < 400) begin
      @(posedge pclk); #1;
      k++;
    end
    check("framing_rxrdy", rxrdy[1], 1'b1);
    check("framing_err_port", fe[1], 1'b1);
    apb_rd(1, 5'h04, v); check("framing_data", v, 8'h00);
    do_reset();
    ovr_en = 1'b1; ovr_val = 1'b0;
    repeat (3) @(posedge pclk);
    #1 ovr_val = 1'b1;
    repeat (400) @(posedge pclk);
    #1 check("glitch_no_rxrdy", rxrdy[1], 1'b0);
    apb_rd(1, 5'h10, v); check("glitch_status", v, 8'h01);
    ovr_en = 1'b0;
    apb_wr(2, 5'h08, 8'hFF);
    apb_rd(2, 5'h08, v); check("fixed_ctrl1", v, 8'hA5);
    apb_wr(2, 5'h0C, 8'h00);
    apb_rd(2, 5'h0C, v); check("fixed_ctrl2", v, 8'h0F);
    apb_wr(0, 5'h00, 8'h00);
    repeat (40) @(posedge pclk);
    #1 presetn = 1'b0;
    @(posedge pclk);
    #1 check("midframe_reset_tx", tx[0], 1'b1);
    check("midframe_reset_txrdy", txrdy[0], 1'b1);
    presetn = 1'b1;
    repeat (400) @(posedge pclk);
    #1 check("midframe_reset_no_rx", rxrdy[1], 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
